// File: rtl/dbg_mem_dump.sv
// dbg_mem_dump: walks a word range over the debug memory port and streams the words out as bytes.
// Define DBG_DUMP_CSUM_EN to append a two's-complement checksum byte after the last word.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | present read address on debug port
// WAIT  | count out read latency, capture word
// SEND  | stream captured word, LSB first
// NEXT  | advance address, decrement word count
// CSUM  | emit checksum byte (feature build only)
// DONE  | one-cycle completion pulse
module dbg_mem_dump #(
    parameter int ADR_W  = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [ADR_W-1:0] start_adr,
    input  logic [LEN_W-1:0] start_len,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
    output logic             dbg_mem_op,
    output logic [3:0]       dbg_wren,
    output logic [ADR_W-1:0] dbg_adr,
    input  logic [31:0]      dbg_di,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int LAT_W = 3;

`ifdef DBG_DUMP_CSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_SEND, S_NEXT, S_DONE, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_SEND, S_NEXT, S_DONE
    } state_t;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [ADR_W-1:0]   r_adr;
    logic [LEN_W-1:0]   r_cnt;
    logic [LAT_W-1:0]   r_lat;
    logic [31:0]        r_word;
    logic [1:0]         r_idx;
    logic [7:0]         w_byte;
    logic [1:0]         w_unused_adr_lsb;
`ifdef DBG_DUMP_CSUM_EN
    logic [7:0]         r_sum;
`endif

    assign w_unused_adr_lsb = start_adr[1:0];
    assign dbg_wren         = 4'h0;
    assign dbg_adr          = r_adr;

    always_comb begin
        case (r_idx)
            2'd0:    w_byte = r_word[7:0];
            2'd1:    w_byte = r_word[15:8];
            2'd2:    w_byte = r_word[23:16];
            default: w_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        busy       = (r_state != S_IDLE);
        cpu_hold   = (r_state != S_IDLE);
        done       = 1'b0;
        dbg_mem_op = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (r_state)
            S_IDLE:  if (start) w_next = (start_len == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                dbg_mem_op = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                dbg_mem_op = 1'b1;
                if (r_lat == LAT_W'(1)) w_next = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = w_byte;
                if (tx_ready && r_idx == 2'd3) w_next = S_NEXT;
            end
            S_NEXT: begin
`ifdef DBG_DUMP_CSUM_EN
                w_next = (r_cnt == LEN_W'(1)) ? S_CSUM : S_ISSUE;
`else
                w_next = (r_cnt == LEN_W'(1)) ? S_DONE : S_ISSUE;
`endif
            end
`ifdef DBG_DUMP_CSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = 8'h00 - r_sum;
                if (tx_ready) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_adr  <= '0;
            r_cnt  <= '0;
            r_lat  <= '0;
            r_word <= '0;
            r_idx  <= 2'd0;
`ifdef DBG_DUMP_CSUM_EN
            r_sum  <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_adr <= {start_adr[ADR_W-1:2], 2'b00};
                    r_cnt <= start_len;
                    r_idx <= 2'd0;
`ifdef DBG_DUMP_CSUM_EN
                    r_sum <= 8'h00;
`endif
                end
                S_ISSUE: r_lat <= LAT_W'(RD_LAT);
                S_WAIT: begin
                    r_lat <= r_lat - LAT_W'(1);
                    if (r_lat == LAT_W'(1)) begin
                        r_word <= dbg_di;
                        r_idx  <= 2'd0;
                    end
                end
                S_SEND: if (tx_ready) begin
                    r_idx <= r_idx + 2'd1;
`ifdef DBG_DUMP_CSUM_EN
                    r_sum <= r_sum + w_byte;
`endif
                end
                S_NEXT: begin
                    r_cnt <= r_cnt - LEN_W'(1);
                    r_adr <= r_adr + ADR_W'(4);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_mem_dump.sv
// tb_dbg_mem_dump: directed bench for dbg_mem_dump with a one-cycle-latency debug memory model.
// Expected byte streams include the checksum byte when DBG_DUMP_CSUM_EN is defined.
module tb_dbg_mem_dump;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_adr = '0;
    logic [15:0] start_len = '0;
    logic        busy, done, cpu_hold, dbg_mem_op, tx_valid;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_di = '0;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];
    logic [7:0]  bytes_q[$];
    logic [31:0] adrs_q[$];
    logic [31:0] exp_w[$];
    int          done_cnt = 0;
    bit          rdy_mode = 0;
    int          rcnt = 0;
    bit          prev_op = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    int          cyc;

    dbg_mem_dump dut (
        .CLK(CLK), .RESET(RESET), .start(start), .start_adr(start_adr), .start_len(start_len),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .dbg_mem_op(dbg_mem_op),
        .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_di(dbg_di),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    always @(posedge CLK) if (dbg_mem_op) dbg_di <= mem_rd(dbg_adr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        rcnt++;
        tx_ready = rdy_mode ? (rcnt % 3 == 0) : 1'b1;
    end

    // Observe bus, byte stream and done pulses; stalled bytes must not change.
    always @(negedge CLK) begin
        if (!RESET) begin
            prev_stall = 0;
            prev_op = 0;
        end else begin
            if (prev_stall) chk("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (dbg_mem_op && !prev_op) adrs_q.push_back(dbg_adr);
            if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
            if (done) done_cnt++;
            prev_op    = dbg_mem_op;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic run_dump(input logic [31:0] adr, input logic [15:0] len, input bit spam,
                            output int ncyc);
        bit got_done = 0;
        bit hold_bad = 0;
        bytes_q.delete();
        adrs_q.delete();
        done_cnt = 0;
        @(posedge CLK); #1;
        start = 1'b1; start_adr = adr; start_len = len;
        @(posedge CLK); #1;
        start = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            ncyc++;
            if (!cpu_hold) hold_bad = 1;
            if (done) begin
                got_done = 1;
                break;
            end
            start = spam && (i % 5 == 2);
        end
        start = 1'b0;
        chk("done_seen", 64'(got_done), 64'd1);
        @(negedge CLK);
        chk("hold_after", {busy, cpu_hold}, 2'b00);
        chk("done_cnt", 64'(done_cnt), 64'd1);
        chk("hold_thru", 64'(hold_bad), 64'd0);
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] exp_b[$];
        logic [7:0] sum = 8'h00;
        foreach (exp_w[k]) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] w;
                w = exp_w[k] >> (8 * b);
                exp_b.push_back(w[7:0]);
                sum = sum + w[7:0];
            end
        end
`ifdef DBG_DUMP_CSUM_EN
        exp_b.push_back(8'h00 - sum);
`endif
        chk({tag, "_nbytes"}, 64'(bytes_q.size()), 64'(exp_b.size()));
        foreach (exp_b[k]) begin
            if (k < bytes_q.size()) chk($sformatf("%s_b%0d", tag, k), 64'(bytes_q[k]), 64'(exp_b[k]));
        end
    endtask

    initial begin
        #1;
        chk("rst_out", {busy, done, cpu_hold, dbg_mem_op, tx_valid, dbg_wren, tx_data, dbg_adr}, 64'd0);
        #20 RESET = 1'b1;

        // single word, byte order
        mem[32'h0] = 32'h11223344;
        run_dump(32'h0, 16'd1, 0, cyc);
        chk("t1_b0", 64'(bytes_q.size() > 0 ? bytes_q[0] : 8'hxx), 64'h44);
        chk("t1_b3", 64'(bytes_q.size() > 3 ? bytes_q[3] : 8'hxx), 64'h11);
        chk("t1_adr", 64'(adrs_q.size() > 0 ? adrs_q[0] : 32'hx), 64'h0);
        exp_w = '{32'h11223344};
        check_bytes("t1");

        // three regions
        mem[32'h0]     = 32'h000000AA;
        mem[32'h10000] = 32'h000000BB;
        mem[32'h20020] = 32'h000000CC;
        run_dump(32'h0, 16'd1, 0, cyc);
        exp_w = '{32'h000000AA};
        check_bytes("ram");
        run_dump(32'h10000, 16'd1, 0, cyc);
        exp_w = '{32'h000000BB};
        check_bytes("mmio");
        run_dump(32'h20020, 16'd1, 0, cyc);
        exp_w = '{32'h000000CC};
        check_bytes("rom");

        // unaligned start with backpressure
        mem[32'h20000] = 32'hDEADBEEF;
        mem[32'h20004] = 32'h01234567;
        mem[32'h20008] = 32'h89ABCDEF;
        rdy_mode = 1;
        run_dump(32'h20003, 16'd3, 0, cyc);
        rdy_mode = 0;
        chk("bp_nrd", 64'(adrs_q.size()), 64'd3);
        if (adrs_q.size() == 3) begin
            chk("bp_rd0", 64'(adrs_q[0]), 64'h20000);
            chk("bp_rd1", 64'(adrs_q[1]), 64'h20004);
            chk("bp_rd2", 64'(adrs_q[2]), 64'h20008);
        end
        exp_w = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        check_bytes("bp");

        // zero length
        run_dump(32'h0, 16'd0, 0, cyc);
        chk("z_nrd", 64'(adrs_q.size()), 64'd0);
        chk("z_nbytes", 64'(bytes_q.size()), 64'd0);
        chk("z_fast", 64'(cyc <= 3), 64'd1);

        // start pulses during a dump are dropped
        mem[32'h0] = 32'h03020100;
        mem[32'h4] = 32'h07060504;
        mem[32'h8] = 32'h0B0A0908;
        mem[32'hC] = 32'h0F0E0D0C;
        run_dump(32'h0, 16'd4, 1, cyc);
        chk("sp_nrd", 64'(adrs_q.size()), 64'd4);
        exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        check_bytes("sp");
        repeat (3) @(negedge CLK);
        chk("sp_idle", {busy, dbg_mem_op, tx_valid}, 3'b000);

        // abort by reset during word 2
        bytes_q.delete();
        done_cnt = 0;
        @(posedge CLK); #1;
        start = 1'b1; start_adr = 32'h0; start_len = 16'd4;
        @(posedge CLK); #1;
        start = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge CLK);
                if (tx_valid && bytes_q.size() >= 5) begin
                    hit = 1;
                    break;
                end
            end
            chk("ab_reach", 64'(hit), 64'd1);
        end
        RESET = 1'b0;
        #1;
        chk("ab_out", {busy, done, cpu_hold, dbg_mem_op, tx_valid, dbg_wren, tx_data, dbg_adr}, 64'd0);
        repeat (3) @(negedge CLK);
        chk("ab_nodone", 64'(done_cnt), 64'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        chk("ab_idle", {busy, done}, 2'b00);
        run_dump(32'h20004, 16'd1, 0, cyc);
        exp_w = '{32'h01234567};
        check_bytes("ab_clean");

`ifdef DBG_DUMP_CSUM_EN
        mem[32'h40] = 32'h01020304;
        run_dump(32'h40, 16'd1, 0, cyc);
        chk("cs_n", 64'(bytes_q.size()), 64'd5);
        chk("cs_byte", 64'(bytes_q.size() == 5 ? bytes_q[4] : 8'hxx), 64'hF6);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
